// File: rtl/exp_arbiter.sv
// Prioritising exception arbiter: synchronise/edge-detect sources, pend, mask, nest, request with vector.
// Optional EXP_LOST_CNT_EN macro enables the saturating dropped-edge counter on lost_cnt.
module exp_arbiter #(
  parameter int          NSRC        = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0040
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            cpu_ack,
  input  logic            eret,
  output logic            irq,
  output logic [2:0]      irq_id,
  output logic [31:0]     vector,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [NSRC-1:0] mask,
  output logic [7:0]      lost_cnt
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RUN = 2'd2} state_e;

  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_r;
  logic [NSRC-1:0] prev_r;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] in_service_r;
  logic [NSRC-1:0] mask_r;
  logic            irq_r;
  logic [2:0]      irq_id_r;
  logic [31:0]     vector_r;

  state_e          state_s;
  logic [NSRC-1:0] rise_s;
  logic            ack_take_s;
  logic [NSRC-1:0] ack_clr_s;
  logic [NSRC-1:0] pend_nxt_s;
  logic [NSRC-1:0] is_nxt_s;
  logic [NSRC-1:0] mask_nxt_s;
  logic [NSRC-1:0] elig_s;
  logic [2:0]      top_s;
  logic [31:0]     vec_s;

  function automatic logic [2:0] top_idx(input logic [NSRC-1:0] v);
    top_idx = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) top_idx = 3'(i);
    end
  endfunction

  function automatic logic [NSRC-1:0] clear_top(input logic [NSRC-1:0] v);
    logic [2:0] t;
    t = top_idx(v);
    clear_top = v;
    for (int i = 0; i < NSRC; i++) begin
      if (t == 3'(i)) clear_top[i] = 1'b0;
    end
  endfunction

  // A source may request only if no in-service level sits at or above its index
  function automatic logic [NSRC-1:0] above_lvl(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) begin
      above_lvl[i] = ((v >> i) == {NSRC{1'b0}});
    end
  endfunction

  // Next-state evaluation for pending, in-service, mask and the request outputs
  always_comb begin
    state_s    = ST_IDLE;
    rise_s     = sync_r[SYNC_STAGES-1] & ~prev_r;
    ack_take_s = 1'b0;
    ack_clr_s  = {NSRC{1'b0}};
    is_nxt_s   = in_service_r;
    mask_nxt_s = mask_r;

    if (irq_r) begin
      state_s = ST_REQ;
    end else if (in_service_r != {NSRC{1'b0}}) begin
      state_s = ST_RUN;
    end else begin
      state_s = ST_IDLE;
    end

    // eret has priority: a coincident ack leaves the request pending
    ack_take_s = cpu_ack && !eret && (state_s == ST_REQ);
    for (int i = 0; i < NSRC; i++) begin
      ack_clr_s[i] = ack_take_s && (irq_id_r == 3'(i));
    end

    if (eret) begin
      is_nxt_s = clear_top(in_service_r);
    end else if (ack_take_s) begin
      is_nxt_s = in_service_r | ack_clr_s;
    end else begin
      is_nxt_s = in_service_r;
    end

    if (mask_we) begin
      mask_nxt_s = mask_wdata;
    end else begin
      mask_nxt_s = mask_r;
    end

    pend_nxt_s = (pending_r & ~ack_clr_s) | rise_s;
    elig_s     = pend_nxt_s & ~mask_nxt_s & above_lvl(is_nxt_s);
    top_s      = top_idx(elig_s);
    vec_s      = VEC_BASE + 32'(top_s) * VEC_STRIDE;
  end

  // Synchroniser chain and edge-detect history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= '0;
      prev_r <= {NSRC{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], src_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Architectural state and registered request outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r    <= {NSRC{1'b0}};
      in_service_r <= {NSRC{1'b0}};
      mask_r       <= {NSRC{1'b1}};
      irq_r        <= 1'b0;
      irq_id_r     <= 3'd0;
      vector_r     <= 32'd0;
    end else begin
      pending_r    <= pend_nxt_s;
      in_service_r <= is_nxt_s;
      mask_r       <= mask_nxt_s;
      irq_r        <= (elig_s != {NSRC{1'b0}});
      if (elig_s != {NSRC{1'b0}}) begin
        irq_id_r <= top_s;
        vector_r <= vec_s;
      end else begin
        irq_id_r <= irq_id_r;
        vector_r <= vector_r;
      end
    end
  end

`ifdef EXP_LOST_CNT_EN
  logic [NSRC-1:0] drop_s;
  logic [8:0]      lost_sum_s;
  logic [7:0]      lost_cnt_r;

  function automatic logic [3:0] popcount(input logic [NSRC-1:0] v);
    popcount = 4'd0;
    for (int i = 0; i < NSRC; i++) begin
      popcount = popcount + {3'd0, v[i]};
    end
  endfunction

  // An edge arriving while its ack clears pending is accepted, not dropped
  always_comb begin
    drop_s     = rise_s & pending_r & ~ack_clr_s;
    lost_sum_s = {1'b0, lost_cnt_r} + {5'd0, popcount(drop_s)};
  end

  // Saturating count of dropped edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost_cnt_r <= 8'd0;
    end else if (lost_sum_s[8]) begin
      lost_cnt_r <= 8'hFF;
    end else begin
      lost_cnt_r <= lost_sum_s[7:0];
    end
  end

  assign lost_cnt = lost_cnt_r;
`else
  assign lost_cnt = 8'd0;
`endif

  assign irq        = irq_r;
  assign irq_id     = irq_id_r;
  assign vector     = vector_r;
  assign pending    = pending_r;
  assign in_service = in_service_r;
  assign mask       = mask_r;

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed self-checking bench for exp_arbiter (default parameters, NSRC=3).
// Expected lost_cnt depends on whether EXP_LOST_CNT_EN is defined.
module tb_exp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_in;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        cpu_ack;
  logic        eret;
  logic        irq;
  logic [2:0]  irq_id;
  logic [31:0] vector;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [2:0]  mask;
  logic [7:0]  lost_cnt;

  int errors = 0;
  int checks = 0;

`ifdef EXP_LOST_CNT_EN
  localparam logic [31:0] LOST_100 = 32'd100;
  localparam logic [31:0] LOST_SAT = 32'd255;
`else
  localparam logic [31:0] LOST_100 = 32'd0;
  localparam logic [31:0] LOST_SAT = 32'd0;
`endif

  exp_arbiter dut (
    .clk(clk), .reset(reset), .src_in(src_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .cpu_ack(cpu_ack), .eret(eret), .irq(irq), .irq_id(irq_id), .vector(vector),
    .pending(pending), .in_service(in_service), .mask(mask), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [2:0] v);
    mask_we = 1'b1; mask_wdata = v; tick(); mask_we = 1'b0;
  endtask

  task automatic do_ack();
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic raise(input logic [2:0] v);
    src_in = src_in | v; repeat (3) tick();
  endtask

  task automatic lower(input logic [2:0] v);
    src_in = src_in & ~v; repeat (3) tick();
  endtask

  task automatic check_req(input string tag, input logic [2:0] id, input logic [31:0] vec);
    check_eq({tag, ".irq"}, {31'd0, irq}, 32'd1);
    check_eq({tag, ".id"}, {29'd0, irq_id}, {29'd0, id});
    check_eq({tag, ".vec"}, vector, vec);
  endtask

  initial begin
    reset = 1'b0; src_in = 3'b000; mask_we = 1'b0; mask_wdata = 3'b000;
    cpu_ack = 1'b0; eret = 1'b0;
    tick(); tick();
    check_eq("rst.irq", {31'd0, irq}, 32'd0);
    check_eq("rst.mask", {29'd0, mask}, 32'd7);
    check_eq("rst.pend", {29'd0, pending}, 32'd0);
    check_eq("rst.lost", {24'd0, lost_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Reset mid-operation with pending=101, in_service=010
    set_mask(3'b000);
    check_eq("t1.mask0", {29'd0, mask}, 32'd0);
    raise(3'b010); lower(3'b010);
    do_ack();
    check_eq("t1.is", {29'd0, in_service}, 32'd2);
    raise(3'b101);
    check_eq("t1.pend", {29'd0, pending}, 32'd5);
    check_req("t1.req", 3'd2, 32'h880);
    reset = 1'b0; src_in = 3'b000;
    #2;
    check_eq("t1.r.irq", {31'd0, irq}, 32'd0);
    check_eq("t1.r.pend", {29'd0, pending}, 32'd0);
    check_eq("t1.r.is", {29'd0, in_service}, 32'd0);
    check_eq("t1.r.mask", {29'd0, mask}, 32'd7);
    check_eq("t1.r.id", {29'd0, irq_id}, 32'd0);
    check_eq("t1.r.vec", vector, 32'd0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check_eq("t1.post.irq", {31'd0, irq}, 32'd0);

    // Basic request/ack/eret on source 1 with latency check
    set_mask(3'b000);
    src_in[1] = 1'b1;
    tick(); tick();
    check_eq("t2.pend2", {29'd0, pending}, 32'd0);
    tick();
    check_eq("t2.pend3", {29'd0, pending}, 32'd2);
    check_req("t2.req", 3'd1, 32'h840);
    lower(3'b010);
    do_ack();
    check_eq("t2.ack.is", {29'd0, in_service}, 32'd2);
    check_eq("t2.ack.irq", {31'd0, irq}, 32'd0);
    check_eq("t2.ack.pend", {29'd0, pending}, 32'd0);
    do_eret();
    check_eq("t2.eret.is", {29'd0, in_service}, 32'd0);

    // Nesting
    raise(3'b001);
    check_req("t3.s0", 3'd0, 32'h800);
    lower(3'b001);
    do_ack();
    check_eq("t3.is1", {29'd0, in_service}, 32'd1);
    raise(3'b100);
    check_req("t3.s2", 3'd2, 32'h880);
    lower(3'b100);
    do_ack();
    check_eq("t3.is5", {29'd0, in_service}, 32'd5);
    check_eq("t3.irq0", {31'd0, irq}, 32'd0);
    raise(3'b010);
    check_eq("t3.p1", {29'd0, pending}, 32'd2);
    check_eq("t3.blk", {31'd0, irq}, 32'd0);
    lower(3'b010);
    do_eret();
    check_eq("t3.eret.is", {29'd0, in_service}, 32'd1);
    check_req("t3.s1", 3'd1, 32'h840);
    do_ack(); do_eret(); do_eret();
    check_eq("t3.clean", {29'd0, in_service}, 32'd0);

    // Simultaneous sources, eret+ack collision, re-trigger during handler
    raise(3'b101);
    check_req("t4.first", 3'd2, 32'h880);
    lower(3'b101);
    cpu_ack = 1'b1; eret = 1'b1; tick(); cpu_ack = 1'b0; eret = 1'b0;
    check_eq("t4.col.pend", {29'd0, pending}, 32'd5);
    check_eq("t4.col.is", {29'd0, in_service}, 32'd0);
    check_req("t4.col", 3'd2, 32'h880);
    do_ack();
    check_eq("t4.ack.is", {29'd0, in_service}, 32'd4);
    check_eq("t4.ack.irq", {31'd0, irq}, 32'd0);
    raise(3'b100);
    check_eq("t4.rt.pend", {29'd0, pending}, 32'd5);
    check_eq("t4.rt.irq", {31'd0, irq}, 32'd0);
    lower(3'b100);
    do_eret();
    check_req("t4.again", 3'd2, 32'h880);
    do_ack(); do_eret();
    check_req("t4.s0", 3'd0, 32'h800);
    do_ack(); do_eret();
    check_eq("t4.clean", {29'd0, pending | in_service}, 32'd0);

    // Mask, ignored ack while idle, edge coinciding with its own ack
    raise(3'b010); lower(3'b010);
    set_mask(3'b010);
    check_eq("t5.m.irq", {31'd0, irq}, 32'd0);
    check_eq("t5.m.pend", {29'd0, pending}, 32'd2);
    do_ack();
    check_eq("t5.ign.is", {29'd0, in_service}, 32'd0);
    check_eq("t5.ign.pend", {29'd0, pending}, 32'd2);
    set_mask(3'b000);
    check_req("t5.um", 3'd1, 32'h840);
    src_in[1] = 1'b1;
    tick(); tick();
    do_ack();
    check_eq("t5.ew.pend", {29'd0, pending}, 32'd2);
    check_eq("t5.ew.is", {29'd0, in_service}, 32'd2);
    check_eq("t5.ew.lost", {24'd0, lost_cnt}, 32'd0);
    lower(3'b010);
    do_eret();
    check_req("t5.ew.req", 3'd1, 32'h840);
    do_ack(); do_eret();

    // Dropped-edge counter with source 0 pending and masked
    set_mask(3'b001);
    raise(3'b001); lower(3'b001);
    check_eq("t6.pend", {29'd0, pending}, 32'd1);
    check_eq("t6.irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      src_in[0] = 1'b1; tick(); src_in[0] = 1'b0; tick();
    end
    repeat (4) tick();
    check_eq("t6.lost100", {24'd0, lost_cnt}, LOST_100);
    for (int i = 0; i < 200; i++) begin
      src_in[0] = 1'b1; tick(); src_in[0] = 1'b0; tick();
    end
    repeat (4) tick();
    check_eq("t6.lostsat", {24'd0, lost_cnt}, LOST_SAT);
    check_eq("t6.pend.end", {29'd0, pending}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
